// File: rtl/aes_pkg.sv
// AES shared definitions: key-length encoding, per-mode schedule constants,
// GF(2^8) helpers and the forward S-box. Used by the key schedule and by the
// cipher round datapath.
package aes_pkg;

   typedef enum logic [1:0] {
      KL128 = 2'd0,
      KL192 = 2'd1,
      KL256 = 2'd2
   } key_len_e;

   typedef enum logic {
      IDLE   = 1'b0,
      EXPAND = 1'b1
   } ks_state_e;

   // Deepest word store across all modes (AES-256).
   localparam int unsigned NW_MAX = 60;

   // Key length in 32-bit words.
   function automatic logic [3:0] nk_of(key_len_e kl);
      case (kl)
         KL192:   return 4'd6;
         KL256:   return 4'd8;
         default: return 4'd4;
      endcase
   endfunction

   // Number of rounds.
   function automatic logic [3:0] nr_of(key_len_e kl);
      case (kl)
         KL192:   return 4'd12;
         KL256:   return 4'd14;
         default: return 4'd10;
      endcase
   endfunction

   // Schedule length in words, 4*(Nr+1).
   function automatic logic [5:0] nw_of(key_len_e kl);
      case (kl)
         KL192:   return 6'd52;
         KL256:   return 6'd60;
         default: return 6'd44;
      endcase
   endfunction

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] rot_word(logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] aa;
      acc = '0;
      aa  = a;
      for (int unsigned n = 0; n < 8; n++) begin
         if (b[n]) acc = acc ^ aa;
         aa = xtime(aa);
      end
      return acc;
   endfunction

   // Field inverse as a^254: six square-and-multiply steps build a^127,
   // one final squaring gives a^254. Maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(logic [7:0] a);
      logic [7:0] acc;
      acc = a;
      for (int unsigned n = 0; n < 6; n++) begin
         acc = gf_mul(gf_mul(acc, acc), a);
      end
      return gf_mul(acc, acc);
   endfunction

   // Forward S-box: field inverse followed by the affine transform.
   function automatic logic [7:0] sbox_fwd(logic [7:0] b);
      logic [7:0] v;
      v = gf_inv(b);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
               ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Round-key read bus. master = round datapath issuing reads,
// slave = key schedule returning a registered response one cycle later.
//   rk_rd_en  : read request
//   rk_round  : round index
//   rk_dec    : 1 = decrypt order (round Nr-r)
//   rk_rdata  : 128-bit round key, first word in [127:96]
//   rk_rvalid : response strobe
//   rk_err    : read rejected (no schedule, or round out of range)
interface aes_key_schedule_if;
   logic         rk_rd_en;
   logic [3:0]   rk_round;
   logic         rk_dec;
   logic [127:0] rk_rdata;
   logic         rk_rvalid;
   logic         rk_err;

   modport master (
      output rk_rd_en, rk_round, rk_dec,
      input  rk_rdata, rk_rvalid, rk_err
   );

   modport slave (
      input  rk_rd_en, rk_round, rk_dec,
      output rk_rdata, rk_rvalid, rk_err
   );
endinterface

// File: rtl/aes_subword.sv
// SubWord: four parallel forward S-box lookups, purely combinational.
//   din  : 32-bit input word
//   dout : each byte of din substituted through the S-box
module aes_subword
   import aes_pkg::*;
(
   input  logic [31:0] din,
   output logic [31:0] dout
);

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      assign dout[8*g +: 8] = sbox_fwd(din[8*g +: 8]);
   end

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key schedule. On start the key words are loaded in one
// cycle, then one schedule word is produced per cycle into a register store.
// Once complete, any round key can be read in encrypt or decrypt order with
// one cycle of latency.
//   clk_sys, rst : clock, asynchronous active-high reset
//   start        : load cipher_key and expand (sampled in IDLE only)
//   key_len      : 0=128, 1=192, 2=256, 3=illegal
//   cipher_key   : MSB-aligned key, w0 in the top 32 bits
//   busy         : expansion in progress
//   done         : one-cycle pulse after the final word is written
//   key_valid    : stored schedule complete and readable
//   cfg_err      : one-cycle pulse on start with unsupported key_len
//   rk           : round-key read bus (slave side)
module aes_key_schedule
   import aes_pkg::*;
#(
   parameter int unsigned MAX_KEY_BITS = 256,
   parameter int unsigned RD_LATENCY   = 1
) (
   input  logic                    clk_sys,
   input  logic                    rst,
   input  logic                    start,
   input  logic [1:0]              key_len,
   input  logic [MAX_KEY_BITS-1:0] cipher_key,
   output logic                    busy,
   output logic                    done,
   output logic                    key_valid,
   output logic                    cfg_err,
   aes_key_schedule_if.slave       rk
);

   if (RD_LATENCY != 1) begin : g_bad_latency
      $error("aes_key_schedule: RD_LATENCY must be 1");
   end
   if (MAX_KEY_BITS != 128 && MAX_KEY_BITS != 192 && MAX_KEY_BITS != 256) begin : g_bad_keybits
      $error("aes_key_schedule: MAX_KEY_BITS must be 128, 192 or 256");
   end

   localparam int unsigned NW_DEPTH = (MAX_KEY_BITS == 128) ? 44 :
                                      (MAX_KEY_BITS == 192) ? 52 : NW_MAX;

   ks_state_e    state_q, state_d;
   key_len_e     kl_q, kl_d;
   logic [5:0]   i_q, i_d;
   logic [2:0]   k_q, k_d;
   logic [7:0]   rcon_q, rcon_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         key_valid_q, key_valid_d;
   logic         cfg_err_q, cfg_err_d;
   logic [127:0] rdata_q, rdata_d;
   logic         rvalid_q, rvalid_d;
   logic         rerr_q, rerr_d;

   logic [31:0]  w_q [NW_DEPTH];

   logic [255:0] key_pad;
   logic [31:0]  key_w [8];
   logic         kl_legal;
   logic [3:0]   nk_in;
   logic [3:0]   nk_cur;
   logic [3:0]   nr_cur;
   logic [5:0]   nw_cur;
   logic [31:0]  prev_word;
   logic [31:0]  back_word;
   logic [31:0]  sw_in;
   logic [31:0]  sw_out;
   logic [31:0]  temp;
   logic [31:0]  wr_word;
   logic         ld_en;
   logic         wr_en;
   logic [3:0]   rsel;
   logic [5:0]   base;

   // Left-align the key in a 256-bit field so word j is always at the same slice.
   always_comb begin
      key_pad = '0;
      key_pad[255 -: MAX_KEY_BITS] = cipher_key;
   end

   for (genvar g = 0; g < 8; g++) begin : g_key_words
      assign key_w[g] = key_pad[255-32*g -: 32];
   end

   assign kl_legal = (key_len != 2'd3) &&
                     ((int'(key_len) * 64 + 128) <= int'(MAX_KEY_BITS));
   assign nk_in    = nk_of(key_len_e'(key_len));
   assign nk_cur   = nk_of(kl_q);
   assign nr_cur   = nr_of(kl_q);
   assign nw_cur   = nw_of(kl_q);

   // Expansion datapath: w[i] = w[i-Nk] ^ f(w[i-1]).
   assign prev_word = w_q[i_q - 6'd1];
   assign back_word = w_q[i_q - {2'b00, nk_cur}];
   assign sw_in     = (k_q == 3'd0) ? rot_word(prev_word) : prev_word;

   aes_subword u_subword (
      .din  (sw_in),
      .dout (sw_out)
   );

   always_comb begin
      temp = prev_word;
      if (k_q == 3'd0) begin
         temp = sw_out ^ {rcon_q, 24'h000000};
      end else if (nk_cur == 4'd8 && k_q == 3'd4) begin
         temp = sw_out;
      end
   end

   assign wr_word = back_word ^ temp;

   // Control: next-state and registered-output values.
   always_comb begin
      state_d     = state_q;
      kl_d        = kl_q;
      i_d         = i_q;
      k_d         = k_q;
      rcon_d      = rcon_q;
      busy_d      = busy_q;
      key_valid_d = key_valid_q;
      done_d      = 1'b0;
      cfg_err_d   = 1'b0;
      ld_en       = 1'b0;
      wr_en       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (kl_legal) begin
                  ld_en       = 1'b1;
                  kl_d        = key_len_e'(key_len);
                  i_d         = {2'b00, nk_in};
                  k_d         = '0;
                  rcon_d      = 8'h01;
                  key_valid_d = 1'b0;
                  busy_d      = 1'b1;
                  state_d     = EXPAND;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         EXPAND: begin
            wr_en = 1'b1;
            i_d   = i_q + 6'd1;
            k_d   = ({1'b0, k_q} == nk_cur - 4'd1) ? 3'd0 : k_q + 3'd1;
            if (k_q == 3'd0) rcon_d = xtime(rcon_q);
            if (i_q == nw_cur - 6'd1) begin
               state_d     = IDLE;
               busy_d      = 1'b0;
               key_valid_d = 1'b1;
               done_d      = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Read port. Uses the key_valid/kl values from before this edge, so a read
   // coinciding with start sees the previous schedule.
   always_comb begin
      rvalid_d = rk.rk_rd_en;
      rerr_d   = 1'b0;
      rdata_d  = '0;
      rsel     = rk.rk_dec ? (nr_cur - rk.rk_round) : rk.rk_round;
      base     = {rsel, 2'b00};
      if (rk.rk_rd_en) begin
         if (!key_valid_q || rk.rk_round > nr_cur) begin
            rerr_d = 1'b1;
         end else begin
            rdata_d = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};
         end
      end
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         kl_q        <= KL128;
         i_q         <= '0;
         k_q         <= '0;
         rcon_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         key_valid_q <= 1'b0;
         cfg_err_q   <= 1'b0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         rerr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         kl_q        <= kl_d;
         i_q         <= i_d;
         k_q         <= k_d;
         rcon_q      <= rcon_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         key_valid_q <= key_valid_d;
         cfg_err_q   <= cfg_err_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         rerr_q      <= rerr_d;
      end
   end

   // Word store: no reset, contents are qualified by key_valid.
   always_ff @(posedge clk_sys) begin
      if (ld_en) begin
         for (int unsigned j = 0; j < 8; j++) begin
            if (4'(j) < nk_in) w_q[6'(j)] <= key_w[3'(j)];
         end
      end
      if (wr_en) begin
         w_q[i_q] <= wr_word;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign key_valid    = key_valid_q;
   assign cfg_err      = cfg_err_q;
   assign rk.rk_rdata  = rdata_q;
   assign rk.rk_rvalid = rvalid_q;
   assign rk.rk_err    = rerr_q;

endmodule
